// File: rtl/pin_saida_serializer.sv
// Serialises each new PIO out_port value onto a 74HC595-style sclk/sdata/latch link.
// Optional build macro PIN_SAIDA_SER_PARITY_EN appends an even-parity bit to each frame.
module pin_saida_serializer #(
    parameter int DATA_W    = 4,
    parameter int CLK_DIV   = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] port_in,
    output logic              sclk,
    output logic              sdata,
    output logic              latch,
    output logic              busy
);

`ifdef PIN_SAIDA_SER_PARITY_EN
    localparam int NBITS = DATA_W + 1;
`else
    localparam int NBITS = DATA_W;
`endif
    localparam int DIV_W = $clog2(CLK_DIV) + 1;
    localparam int BIT_W = $clog2(DATA_W + 1) + 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(NBITS - 1);

    typedef enum logic [1:0] {IDLE, SHIFT_LO, SHIFT_HI, LATCH} state_t;

    state_t            state;
    logic [DATA_W-1:0] sent_reg;
    logic              force_tx;
    logic [DIV_W-1:0]  div_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic [NBITS-1:0]  shift_reg;

    // Frame layout puts the parity bit at the end that leaves the register last.
    function automatic logic [NBITS-1:0] frame_of(input logic [DATA_W-1:0] v);
`ifdef PIN_SAIDA_SER_PARITY_EN
        if (MSB_FIRST != 0) return {v, ^v};
        else                return {^v, v};
`else
        return v;
`endif
    endfunction

    function automatic logic out_bit(input logic [NBITS-1:0] v);
        return (MSB_FIRST != 0) ? v[NBITS-1] : v[0];
    endfunction

    function automatic logic [NBITS-1:0] shift_out(input logic [NBITS-1:0] v);
        return (MSB_FIRST != 0) ? (v << 1) : (v >> 1);
    endfunction

    logic             start;
    logic             div_done;
    logic             last_bit;
    logic [NBITS-1:0] shift_nxt;

    assign start     = (state == IDLE) && ((port_in != sent_reg) || force_tx);
    assign div_done  = (div_cnt == DIV_LAST);
    assign last_bit  = (bit_cnt == BIT_LAST);
    assign shift_nxt = shift_out(shift_reg);

    // Shift register carries data only, so it is left out of the reset.
    always_ff @(posedge clk) begin
        if (start)
            shift_reg <= frame_of(port_in);
        else if ((state == SHIFT_HI) && div_done && !last_bit)
            shift_reg <= shift_nxt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            sent_reg <= '0;
            force_tx <= 1'b1;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            sclk     <= 1'b0;
            sdata    <= 1'b0;
            latch    <= 1'b0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sent_reg <= port_in;
                        force_tx <= 1'b0;
                        bit_cnt  <= '0;
                        div_cnt  <= '0;
                        busy     <= 1'b1;
                        sclk     <= 1'b0;
                        sdata    <= out_bit(frame_of(port_in));
                        state    <= SHIFT_LO;
                    end
                end
                SHIFT_LO: begin
                    if (div_done) begin
                        div_cnt <= '0;
                        sclk    <= 1'b1;
                        state   <= SHIFT_HI;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                SHIFT_HI: begin
                    if (div_done) begin
                        div_cnt <= '0;
                        sclk    <= 1'b0;
                        if (last_bit) begin
                            latch <= 1'b1;
                            state <= LATCH;
                        end else begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                            sdata   <= out_bit(shift_nxt);
                            state   <= SHIFT_LO;
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                LATCH: begin
                    if (div_done) begin
                        div_cnt <= '0;
                        latch   <= 1'b0;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/pin_saida_serializer.md
Name: pin_saida_serializer

Overview:
- Downstream consumer of the 4-bit Avalon PIO output port (out_port) in the processor system.
- Watches the parallel port value and, on every change, shifts the new value into an external 74HC595-style shift register over three wires: sclk, sdata and latch.
- Lets the processor drive off-chip outputs through a 3-pin serial link instead of DATA_W pins.
- Single clock domain, same clk as the PIO.

Parameters:
- DATA_W, 4: width of the parallel input and number of data bits shifted per transfer.
- CLK_DIV, 4: clk cycles per sclk half-period and per latch pulse; legal range >= 1.
- MSB_FIRST, 1: 1 = bit DATA_W-1 shifted first; 0 = bit 0 shifted first.

Ports:
- clk, input, 1: system clock.
- reset_n, input, 1: asynchronous, active-low reset.
- port_in, input, DATA_W: parallel value from PIO out_port; synchronous to clk, no synchroniser.
- sclk, output, 1: serial shift clock; the external register samples on the rising edge.
- sdata, output, 1: serial data; stable for the whole sclk high phase.
- latch, output, 1: storage-register strobe; active high, CLK_DIV cycles wide.
- busy, output, 1: high while a transfer is in progress.

Behaviour:
- Reset values: all outputs are registered; sclk=0, sdata=0, latch=0, busy=0.
- Reset internal state: state=IDLE, sent_reg=0, force=1, div_cnt=0, bit_cnt=0.
- Reset is asynchronous. Asserting it mid-transfer aborts the transfer immediately with no latch pulse. After release, force=1 guarantees the current port_in is retransmitted even if it equals 0.
- States are IDLE, SHIFT_LO, SHIFT_HI and LATCH.
- IDLE: when (port_in != sent_reg) or force:
  - shift_reg <= port_in; sent_reg <= port_in; force <= 0.
  - bit_cnt <= 0; div_cnt <= 0; busy <= 1; go to SHIFT_LO.
  - The detection edge counts as no transfer cycle; busy is visible the following cycle.
- SHIFT_LO:
  - sclk=0; sdata = shift_reg[DATA_W-1] if MSB_FIRST, otherwise shift_reg[0].
  - After CLK_DIV cycles: div_cnt <= 0, go to SHIFT_HI.
- SHIFT_HI:
  - sclk=1; sdata held.
  - After CLK_DIV cycles: if bit_cnt == last bit index, go to LATCH.
  - Otherwise shift shift_reg toward the output end, bit_cnt++, go to SHIFT_LO.
- LATCH:
  - sclk=0, latch=1 for CLK_DIV cycles.
  - Then latch=0, busy=0, go to IDLE.
- Transfer length (busy high): 2*DATA_W*CLK_DIV + CLK_DIV cycles. Defaults give 36 cycles.
- Changes of port_in while busy are ignored; the transfer is never restarted or aborted.
- On return to IDLE, port_in is compared again with sent_reg. Only the latest value is sent; intermediate values are dropped by design.
- If port_in returns to sent_reg while busy, no further transfer occurs.
- Back-to-back transfers: with a pending change, IDLE lasts exactly 1 cycle (busy=0 for that one cycle).
- CLK_DIV=1: each phase lasts 1 cycle; the same rules apply.
- div_cnt is sized clog2(CLK_DIV)+1 and wraps only by explicit clear. bit_cnt is sized clog2(DATA_W+1)+1.

Optional Feature:
- Macro: PIN_SAIDA_SER_PARITY_EN.
- Defined:
  - An even-parity bit (XOR of the captured value) is shifted after the data bits.
  - DATA_W+1 bits per transfer; the last bit index is DATA_W.
  - busy length is 2*(DATA_W+1)*CLK_DIV + CLK_DIV cycles (defaults: 44).
- Not defined: exactly DATA_W bits; no parity logic present.

Test Plan:
- Reset release with port_in=0 (defaults):
  - One transfer starts because of force.
  - Four rising sclk edges with sdata=0, then one 4-cycle latch pulse.
  - busy high for exactly 36 cycles.
- port_in 0 -> 4'b1011, MSB_FIRST=1:
  - sdata sampled at rising sclk edges reads 1,0,1,1.
  - latch rises 32 cycles after busy rises.
  - No further transfer while port_in is held.
- port_in 4'b1011 -> 4'b0001 -> 4'b0110 during one transfer:
  - The first transfer completes unchanged.
  - After 1 idle cycle exactly one transfer of 1,0,1,1 serially... corrected expectation: exactly one transfer of 0,1,1,0 (0110); 0001 is never sent.
- Toggle port_in 0x3 -> 0x5 -> 0x3 while sending 0x3: no second transfer; busy stays 0 after the latch pulse.
- Assert reset_n mid-SHIFT_HI of bit 2:
  - sclk, sdata, latch and busy go to 0 asynchronously in the same cycle; no latch pulse.
  - After release the current port_in (0x9) is resent in full.
- PIN_SAIDA_SER_PARITY_EN defined, port_in=4'b0111:
  - Serial bits 0,1,1,1 followed by parity 1.
  - busy high for 44 cycles.
  - CLK_DIV=1 variant: busy high for 11 cycles.
